rank_order_filter: RTL and testbench
====================================

// Module: rank_order_filter
// PURPOSE
//  Parametrised rank-order filter: the successor to the fixed 9-tap median block.
//  - Collects a frame of N unsigned W-bit samples.
//  - Sorts the frame in place with an odd-even transposition network.
//  - Emits the sample of run-time-selectable rank: 0 = min, (N-1)/2 = median, N-1 = max.
//  - Sits in the video pixel path after neighbourhood extraction; feeds the synchro/denoise stage.
// PARAMETERS
//  W     8    sample width, unsigned, 1..32
//  N     9    frame length (samples per result), odd, 3..31
//  RW    $clog2(N)   width of RANK port (derived, do not override)
// PORTS
//  CLK   in   1    single clock, all logic on posedge
//  nRST  in   1    reset: synchronous, active-low
//  DI    in   W    sample data, valid when DSI=1
//  DSI   in   1    sample strobe; must stay high for N consecutive cycles per frame
//  RANK  in   RW   requested rank (0 = smallest); sampled with the first sample of a frame
//  DO    out  W    selected sample; holds its value until the next result
//  DSO   out  1    one-cycle pulse: DO valid
//  READY out  1    high when a new frame may start (IDLE or EMIT)
// BEHAVIOUR
//  - Reset (nRST=0 at posedge): state=IDLE, DO=0, DSO=0, counters=0, sample array cleared.
//    - Reset during any state aborts the frame; no DSO follows.
//  - States: IDLE, LOAD, SORT, EMIT (typedef in package).
//  - IDLE or EMIT, DSI=1:
//    - Capture DI into slot 0; latch RANK, clamping values >= N to N-1.
//    - cnt=1; go to LOAD.
//  - LOAD, DSI=1: DI -> slot cnt, cnt++.
//    - When slot N-1 is written, clear phase counter and go to SORT.
//  - LOAD, DSI=0: abort. Go to IDLE; no DSO; DO unchanged.
//  - SORT: one compare-exchange phase per cycle, N phases.
//    - Even phase: pairs (0,1),(2,3)...  Odd phase: pairs (1,2),(3,4)...
//    - Smaller value moves to the lower index. Equal values are not swapped.
//    - After phase N-1: DO <= slot[rank], DSO <= 1, state -> EMIT.
//  - EMIT: DSO deasserts the next cycle.
//    - DSI=1 starts a new frame, as in IDLE (back-to-back frames).
//    - DSI=0 -> IDLE.
//  - DSI during SORT is ignored. Upstream must honour READY.
//  - Latency: first sample captured on edge e0; DO/DSO update on edge e0+2N.
//    - Frame period is 2N+1 cycles minimum.
//  - Arithmetic: unsigned compare only; no width growth. cnt and phase are $clog2(N+1) bits.
//  - READY = (state==IDLE) || (state==EMIT). Registered-state decode, no DSI path.
// STRUCTURE
//  - Package rank_order_pkg: state enum rof_state_t, N/W legality checks, rank clamp function.
//  - Sub-module cmp_swap #(W): combinational 2-in/2-out min/max cell.
//    - Instantiated floor(N/2) times per phase parity via generate.
//  - Top module holds the sample register array, FSM, counters and output registers.
// TESTING  (N=9, W=8 unless noted)
//  - Samples 9,3,7,1,5,8,2,6,4, RANK=4 -> DO=5, single DSO pulse 18 edges after first capture.
//  - Same frame, RANK=0 -> DO=1; RANK=8 -> DO=9; RANK=15 (clamped) -> DO=9.
//  - All samples 255, RANK=4 -> DO=255; all 0 -> DO=0 (ties, no spurious swap).
//  - DSI low after 4 samples -> no DSO.
//    - READY=1 the next cycle; following full frame 1..9, RANK=4 -> DO=5.
//  - nRST=0 for one cycle mid-SORT -> DO=0, DSO never asserts, READY=1 after reset.
//  - Back-to-back: new frame started in EMIT cycle -> two DSO pulses 19 cycles apart, correct values.
//  - N=3, W=4 build: frame 15,0,7, RANK=1 -> DO=7 at edge e0+6.

Source files
------------

// File: rtl/rank_order_pkg.sv
// Shared types and elaboration helpers for the rank-order filter.
package rank_order_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SORT = 2'd2,
      EMIT = 2'd3
   } rof_state_t;

   // Odd frame length keeps a unique median slot and an idle lane in each phase.
   function automatic bit rof_params_ok(input int n, input int w);
      return (n >= 3) && (n <= 31) && (n % 2 == 1) && (w >= 1) && (w <= 32);
   endfunction

   function automatic int unsigned rof_clamp_rank(input int unsigned rank, input int unsigned n);
      return (rank >= n) ? n - 1 : rank;
   endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange cell: lo = min(a,b), hi = max(a,b).
// Equal inputs pass straight through, so ties never swap.
module cmp_swap #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);

   logic swap;

   assign swap = (b < a);
   assign lo   = swap ? b : a;
   assign hi   = swap ? a : b;

endmodule

// File: rtl/rank_order_filter.sv
// Rank-order filter: collects N samples, sorts them with an odd-even transposition network, emits slot[RANK].
// Result appears 2N edges after the first sample; READY is high in IDLE/EMIT and DSI is ignored while sorting.
module rank_order_filter
   import rank_order_pkg::*;
#(
   parameter  int W  = 8,
   parameter  int N  = 9,
   localparam int RW = $clog2(N)
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic [W-1:0]  DI,
   input  logic          DSI,
   input  logic [RW-1:0] RANK,
   output logic [W-1:0]  DO,
   output logic          DSO,
   output logic          READY
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);
   localparam logic [CW-1:0] PH_DONE   = CW'(N);

   if (!rof_params_ok(N, W)) begin : g_bad_params
      $error("rank_order_filter: N must be odd in 3..31 and W in 1..32");
   end

   rof_state_t    state_q, state_d;
   logic [W-1:0]  slot    [N];
   logic [W-1:0]  ev_out  [N];
   logic [W-1:0]  od_out  [N];
   logic [W-1:0]  net_out [N];
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] phase_q;
   logic [RW-1:0] rank_q;
   logic          start, load, sort_step, emit;

   // Both phase parities are built; phase_q[0] picks which one is committed.
   for (genvar i = 0; i < N / 2; i++) begin : g_pair
      cmp_swap #(.W(W)) u_even (
         .a  (slot[2*i]),
         .b  (slot[2*i+1]),
         .lo (ev_out[2*i]),
         .hi (ev_out[2*i+1])
      );
      cmp_swap #(.W(W)) u_odd (
         .a  (slot[2*i+1]),
         .b  (slot[2*i+2]),
         .lo (od_out[2*i+1]),
         .hi (od_out[2*i+2])
      );
   end

   assign ev_out[N-1] = slot[N-1];
   assign od_out[0]   = slot[0];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         net_out[i] = phase_q[0] ? od_out[i] : ev_out[i];
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      load      = 1'b0;
      sort_step = 1'b0;
      emit      = 1'b0;
      case (state_q)
         IDLE, EMIT: begin
            if (DSI) begin
               start   = 1'b1;
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (DSI) begin
               load = 1'b1;
               if (cnt_q == LAST_SLOT) state_d = SORT;
            end else begin
               state_d = IDLE;
            end
         end
         SORT: begin
            // Phases 0..N-1 run first; the extra cycle reads out the settled array.
            if (phase_q == PH_DONE) begin
               emit    = 1'b1;
               state_d = EMIT;
            end else begin
               sort_step = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < N; i++) slot[i] <= '0;
         cnt_q   <= '0;
         phase_q <= '0;
         rank_q  <= '0;
         DO      <= '0;
         DSO     <= 1'b0;
      end else begin
         DSO <= emit;
         if (start) begin
            slot[0] <= DI;
            rank_q  <= RW'(rof_clamp_rank(32'(RANK), 32'(N)));
            cnt_q   <= CW'(1);
         end else if (load) begin
            slot[cnt_q] <= DI;
            cnt_q       <= cnt_q + CW'(1);
            if (cnt_q == LAST_SLOT) phase_q <= '0;
         end else if (sort_step) begin
            slot    <= net_out;
            phase_q <= phase_q + CW'(1);
         end
         if (emit) DO <= slot[rank_q];
      end
   end

   assign READY = (state_q == IDLE) || (state_q == EMIT);

endmodule

// File: tb/tb_rank_order_filter.sv
// Scoreboard bench for rank_order_filter: N=9/W=8 and N=3/W=4 instances, directed and random frames.
module tb_rank_order_filter;

   typedef struct {
      int unsigned val;
      int unsigned due;
   } exp_t;

   logic       clk   = 1'b0;
   logic       nrst  = 1'b0;
   logic [7:0] di9   = '0;
   logic       dsi9  = 1'b0;
   logic [3:0] rank9 = '0;
   logic [7:0] do9;
   logic       dso9;
   logic       ready9;
   logic [3:0] di3   = '0;
   logic       dsi3  = 1'b0;
   logic [1:0] rank3 = '0;
   logic [3:0] do3;
   logic       dso3;
   logic       ready3;

   int unsigned cyc   = 0;
   int          total = 0;
   int          bad   = 0;
   int unsigned held9 = 0;
   int unsigned held3 = 0;
   exp_t        q9[$];
   exp_t        q3[$];

   rank_order_filter #(.W(8), .N(9)) u_dut9 (
      .CLK   (clk),
      .nRST  (nrst),
      .DI    (di9),
      .DSI   (dsi9),
      .RANK  (rank9),
      .DO    (do9),
      .DSO   (dso9),
      .READY (ready9)
   );

   rank_order_filter #(.W(4), .N(3)) u_dut3 (
      .CLK   (clk),
      .nRST  (nrst),
      .DI    (di3),
      .DSI   (dsi3),
      .RANK  (rank3),
      .DO    (do3),
      .DSO   (dso3),
      .READY (ready3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int unsigned act, input int unsigned want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Reference: sort the frame and index by the clamped rank.
   function automatic int unsigned pick(input int unsigned s[$], input int unsigned rk, input int unsigned n);
      int unsigned t[$];
      int unsigned r;
      t = s;
      t.sort();
      r = (rk >= n) ? n - 1 : rk;
      return t[r];
   endfunction

   always @(posedge clk) begin
      #2;
      if (!nrst) begin
         held9 = 0;
      end else if (dso9) begin
         if (q9.size() == 0) begin
            chk("dso9_spurious", 1, 0);
         end else begin
            exp_t e;
            e = q9.pop_front();
            chk("do9_value", 32'(do9), e.val);
            chk("dso9_cycle", cyc, e.due);
            held9 = e.val;
         end
      end else begin
         chk("do9_hold", 32'(do9), held9);
      end
   end

   always @(posedge clk) begin
      #2;
      if (!nrst) begin
         held3 = 0;
      end else if (dso3) begin
         if (q3.size() == 0) begin
            chk("dso3_spurious", 1, 0);
         end else begin
            exp_t e;
            e = q3.pop_front();
            chk("do3_value", 32'(do3), e.val);
            chk("dso3_cycle", cyc, e.due);
            held3 = e.val;
         end
      end else begin
         chk("do3_hold", 32'(do3), held3);
      end
   end

   task automatic wait_ready(input bit sel3);
      int t;
      t = 0;
      @(negedge clk);
      dsi9 = 1'b0;
      dsi3 = 1'b0;
      while (!(sel3 ? ready3 : ready9) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", 32'(sel3 ? ready3 : ready9), 1);
   endtask

   // Called at a negedge with READY high; returns at the negedge that drove the last sample.
   task automatic send(input bit sel3, input int unsigned s[$], input int unsigned rk,
                       input int len, input bit push, input int unsigned expv);
      int unsigned n;
      int unsigned e0;
      exp_t        e;
      n  = sel3 ? 3 : 9;
      e0 = cyc + 1;
      for (int i = 0; i < len; i++) begin
         if (i > 0) @(negedge clk);
         if (sel3) begin
            dsi3 = 1'b1;
            di3  = 4'(s[i]);
            if (i == 0) rank3 = 2'(rk);
         end else begin
            dsi9 = 1'b1;
            di9  = 8'(s[i]);
            if (i == 0) rank9 = 4'(rk);
         end
      end
      if (push) begin
         e.val = expv;
         e.due = e0 + 2 * n;
         if (sel3) q3.push_back(e);
         else      q9.push_back(e);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned fa[$];
      int unsigned f19[$];
      int unsigned all255[$];
      int unsigned all0[$];
      int unsigned f3[$];
      int unsigned s[$];
      int unsigned rk;
      int          t;

      fa  = '{9, 3, 7, 1, 5, 8, 2, 6, 4};
      f19 = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      f3  = '{15, 0, 7};
      for (int i = 0; i < 9; i++) begin
         all255.push_back(255);
         all0.push_back(0);
      end

      repeat (3) @(negedge clk);
      chk("rst_do9", 32'(do9), 0);
      chk("rst_dso9", 32'(dso9), 0);
      chk("rst_ready9", 32'(ready9), 1);
      chk("rst_do3", 32'(do3), 0);
      chk("rst_ready3", 32'(ready3), 1);
      nrst = 1'b1;

      // Directed frames, each started as soon as READY shows (back-to-back from EMIT).
      wait_ready(0); send(0, fa, 4, 9, 1, 5);
      wait_ready(0); send(0, fa, 0, 9, 1, 1);
      wait_ready(0); send(0, fa, 8, 9, 1, 9);
      wait_ready(0); send(0, fa, 15, 9, 1, 9);
      wait_ready(0); send(0, all255, 4, 9, 1, 255);
      wait_ready(0); send(0, all0, 4, 9, 1, 0);

      // Abort after four samples.
      wait_ready(0); send(0, fa, 4, 4, 0, 0);
      @(negedge clk); dsi9 = 1'b0;
      @(negedge clk);
      chk("ready_after_abort", 32'(ready9), 1);
      wait_ready(0); send(0, f19, 4, 9, 1, 5);

      // Reset pulse in the middle of SORT.
      wait_ready(0); send(0, fa, 4, 9, 0, 0);
      @(negedge clk); dsi9 = 1'b0;
      repeat (3) @(negedge clk);
      chk("sort_ready_low", 32'(ready9), 0);
      nrst = 1'b0;
      @(negedge clk); nrst = 1'b1;
      @(negedge clk);
      chk("midsort_rst_do9", 32'(do9), 0);
      chk("midsort_rst_ready9", 32'(ready9), 1);
      repeat (25) @(negedge clk);

      // Random frames; every third one drawn from a tiny range to force ties.
      for (int f = 0; f < 24; f++) begin
         s = {};
         for (int i = 0; i < 9; i++) s.push_back((f % 3 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255));
         rk = $urandom_range(0, 15);
         wait_ready(0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         send(0, s, rk, 9, 1, pick(s, rk, 9));
      end

      // Small build.
      wait_ready(1); send(1, f3, 1, 3, 1, 7);
      for (int f = 0; f < 12; f++) begin
         s = {};
         for (int i = 0; i < 3; i++) s.push_back($urandom_range(0, 15));
         rk = $urandom_range(0, 3);
         wait_ready(1);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         send(1, s, rk, 3, 1, pick(s, rk, 3));
      end

      @(negedge clk);
      dsi9 = 1'b0;
      dsi3 = 1'b0;
      t = 0;
      while ((q9.size() != 0 || q3.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (30) @(negedge clk);
      chk("q9_drained", 32'(q9.size()), 0);
      chk("q3_drained", 32'(q3.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
